// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared constants, scoreboard slot type and scoreboard actions for hazard_ctrl
package hazard_ctrl_pkg;
    localparam int REG_W = 5;
    localparam int DEF_PIPE_DEPTH = 3;
    typedef logic [REG_W-1:0] reg_addr_t;
    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
    } sb_slot_t;
    typedef enum logic [1:0] {
        ACT_ISSUE,
        ACT_HOLD,
        ACT_BUBBLE
    } sb_act_t;
    function automatic logic rd_live(input logic v, input logic w, input reg_addr_t rd);
        return v && w && rd != '0;
    endfunction
endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: decode-stage operands, pipeline events and the resulting pipeline controls
interface hazard_ctrl_if import hazard_ctrl_pkg::*; #(parameter int CNT_W = 32);
    logic             id_valid;
    reg_addr_t        id_rs1_addr;
    reg_addr_t        id_rs2_addr;
    logic             id_rs1_used;
    logic             id_rs2_used;
    reg_addr_t        id_rd_addr;
    logic             id_rf_w_en;
    logic             ex_redirect;
    logic             mem_busy;
    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_id;
    logic             hazard;
    logic [CNT_W-1:0] stall_cnt;
    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_w_en, ex_redirect, mem_busy,
        input  stall_if, stall_id, bubble_ex, flush_id, hazard, stall_cnt
    );
    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
               id_rd_addr, id_rf_w_en, ex_redirect, mem_busy,
        output stall_if, stall_id, bubble_ex, flush_id, hazard, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight destination tracker (slot 0 = EX, last = WB) with per-slot read-port matches
module hazard_scoreboard import hazard_ctrl_pkg::*; #(
    parameter int DEPTH = DEF_PIPE_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  sb_act_t          act,
    input  sb_slot_t         ins,
    input  reg_addr_t        rs1,
    input  reg_addr_t        rs2,
    output logic [DEPTH-1:0] match1,
    output logic [DEPTH-1:0] match2
);
    sb_slot_t slots [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (act != ACT_HOLD) begin
            slots[0] <= act == ACT_ISSUE ? ins : '0;
            for (int i = 1; i < DEPTH; i++) slots[i] <= slots[i-1];
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        assign match1[g] = slots[g].valid && slots[g].rd == rs1;
        assign match2[g] = slots[g].valid && slots[g].rd == rs2;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW interlock at decode with redirect and memory back-pressure priority,
// plus a saturating count of stalled cycles
module hazard_ctrl import hazard_ctrl_pkg::*; #(
    parameter int PIPE_DEPTH = DEF_PIPE_DEPTH,
    parameter int CNT_W      = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave bus
);
    logic [PIPE_DEPTH-1:0] m1, m2;
    logic                  raw, stall;
    sb_act_t               act;
    sb_slot_t              ins;
    logic [CNT_W-1:0]      cnt;

    hazard_scoreboard #(.DEPTH(PIPE_DEPTH)) u_sb (
        .clk    (clk),
        .reset  (reset),
        .act    (act),
        .ins    (ins),
        .rs1    (bus.id_rs1_addr),
        .rs2    (bus.id_rs2_addr),
        .match1 (m1),
        .match2 (m2)
    );

    always_comb begin
        ins   = {rd_live(bus.id_valid, bus.id_rf_w_en, bus.id_rd_addr), bus.id_rd_addr};
        raw   = bus.id_valid && ((bus.id_rs1_used && bus.id_rs1_addr != '0 && |m1) ||
                                 (bus.id_rs2_used && bus.id_rs2_addr != '0 && |m2));
        act   = bus.mem_busy ? ACT_HOLD : (bus.ex_redirect || raw) ? ACT_BUBBLE : ACT_ISSUE;
        stall = !reset && (bus.mem_busy || (!bus.ex_redirect && raw));
    end

    // a redirect overrides a pending hazard; memory back-pressure overrides both
    assign bus.hazard    = !reset && raw;
    assign bus.stall_if  = stall;
    assign bus.stall_id  = stall;
    assign bus.bubble_ex = !reset && !bus.mem_busy && (bus.ex_redirect || raw);
    assign bus.flush_id  = !reset && !bus.mem_busy && bus.ex_redirect;
    assign bus.stall_cnt = cnt;

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else if (stall && !(&cnt)) cnt <= cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: vector table with an expected-result queue; a narrow-counter twin checks saturation
module tb_hazard_ctrl;
    typedef struct {
        logic       rst, v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       w, rdr, busy;
        logic [4:0] exp;
        int         cnt;
    } vec_t;

    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(32)) bus();
    hazard_ctrl_if #(.CNT_W(3))  bs();

    hazard_ctrl #(.PIPE_DEPTH(3), .CNT_W(32)) dut   (.clk(clk), .reset(reset), .bus(bus));
    hazard_ctrl #(.PIPE_DEPTH(3), .CNT_W(3))  dut_s (.clk(clk), .reset(reset), .bus(bs));

    assign bs.id_valid    = bus.id_valid;
    assign bs.id_rs1_addr = bus.id_rs1_addr;
    assign bs.id_rs2_addr = bus.id_rs2_addr;
    assign bs.id_rs1_used = bus.id_rs1_used;
    assign bs.id_rs2_used = bus.id_rs2_used;
    assign bs.id_rd_addr  = bus.id_rd_addr;
    assign bs.id_rf_w_en  = bus.id_rf_w_en;
    assign bs.ex_redirect = bus.ex_redirect;
    assign bs.mem_busy    = bus.mem_busy;

    vec_t tv[$];
    vec_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // expected flags are packed {hazard, stall_if, stall_id, bubble_ex, flush_id}
    localparam logic [4:0] IDLE = 5'b00000, HZ = 5'b11110, HZ_RD = 5'b10011,
                           HZ_BZ = 5'b11100, BZ = 5'b01100, RD = 5'b00011;

    function automatic vec_t mk(input logic rst, v, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic w, rdr, busy, input logic [4:0] exp, input int cnt);
        vec_t t;
        t = '{rst, v, rs1, u1, rs2, u2, rd, w, rdr, busy, exp, cnt};
        return t;
    endfunction

    task automatic drive(input vec_t t);
        reset           = t.rst;
        bus.id_valid    = t.v;
        bus.id_rs1_addr = t.rs1;
        bus.id_rs1_used = t.u1;
        bus.id_rs2_addr = t.rs2;
        bus.id_rs2_used = t.u2;
        bus.id_rd_addr  = t.rd;
        bus.id_rf_w_en  = t.w;
        bus.ex_redirect = t.rdr;
        bus.mem_busy    = t.busy;
        exp_q.push_back(t);
    endtask

    task automatic check(input int n);
        vec_t e;
        logic [4:0] got;
        logic [2:0] sat;
        e   = exp_q.pop_front();
        got = {bus.hazard, bus.stall_if, bus.stall_id, bus.bubble_ex, bus.flush_id};
        sat = e.cnt > 7 ? 3'd7 : 3'(e.cnt);
        checks++;
        if (got !== e.exp) begin
            errors++;
            $display("FAIL ctl[%0d] {hz,sif,sid,bub,fl} got %b want %b", n, got, e.exp);
        end
        checks++;
        if (bus.stall_cnt !== 32'(e.cnt)) begin
            errors++;
            $display("FAIL cnt[%0d] got %0d want %0d", n, bus.stall_cnt, e.cnt);
        end
        checks++;
        if (bs.stall_cnt !== sat) begin
            errors++;
            $display("FAIL sat_cnt[%0d] got %0d want %0d", n, bs.stall_cnt, sat);
        end
    endtask

    task automatic step(input vec_t t, input int n);
        @(posedge clk);
        #1 drive(t);
        @(negedge clk);
        check(n);
    endtask

    initial begin
        drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 0));
        void'(exp_q.pop_front());
        repeat (2) @(posedge clk);
        // back-to-back dependency: 3 stall cycles then issue
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 5, 1, 0, 0, IDLE, 0));
        tv.push_back(mk(0, 1, 5, 1, 5, 1, 6, 1, 0, 0, HZ, 0));
        tv.push_back(mk(0, 1, 5, 1, 5, 1, 6, 1, 0, 0, HZ, 1));
        tv.push_back(mk(0, 1, 5, 1, 5, 1, 6, 1, 0, 0, HZ, 2));
        tv.push_back(mk(0, 1, 5, 1, 5, 1, 6, 1, 0, 0, IDLE, 3));
        // x0 writer then x0 reader, then id_valid=0 over a live match
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 1, 0, 1, 0, 1, 8, 1, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 0, 8, 1, 8, 1, 8, 1, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 3));
        // distance 3 on rs2: one stall
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 9, 1, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 1, 2, 1, 0, 0, 10, 1, 0, 0, IDLE, 3));
        tv.push_back(mk(0, 1, 3, 1, 7, 1, 11, 1, 0, 0, HZ, 3));
        tv.push_back(mk(0, 1, 3, 1, 7, 1, 11, 1, 0, 0, IDLE, 4));
        // matching but unused sources never hazard
        tv.push_back(mk(0, 1, 11, 0, 10, 0, 0, 0, 0, 0, IDLE, 4));
        // redirect beats hazard
        tv.push_back(mk(0, 1, 11, 1, 0, 0, 17, 1, 1, 0, HZ_RD, 4));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE, 4));
        // mem_busy freezes a 3-cycle stall for 2 cycles -> 5 stall cycles
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 12, 1, 0, 0, IDLE, 4));
        tv.push_back(mk(0, 1, 12, 1, 0, 0, 13, 1, 0, 0, HZ, 4));
        tv.push_back(mk(0, 1, 12, 1, 0, 0, 13, 1, 0, 1, HZ_BZ, 5));
        tv.push_back(mk(0, 1, 12, 1, 0, 0, 13, 1, 0, 1, HZ_BZ, 6));
        tv.push_back(mk(0, 1, 12, 1, 0, 0, 13, 1, 0, 0, HZ, 7));
        tv.push_back(mk(0, 1, 12, 1, 0, 0, 13, 1, 0, 0, HZ, 8));
        tv.push_back(mk(0, 1, 12, 1, 0, 0, 13, 1, 0, 0, IDLE, 9));
        // busy alone, redirect alone, busy beats redirect
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 20, 1, 0, 1, BZ, 9));
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 20, 1, 1, 0, RD, 10));
        tv.push_back(mk(0, 1, 1, 1, 0, 0, 20, 1, 1, 1, BZ, 10));
        // fill all three slots
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 14, 1, 0, 0, IDLE, 11));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 15, 1, 0, 0, IDLE, 11));
        tv.push_back(mk(0, 1, 0, 0, 0, 0, 16, 1, 0, 0, IDLE, 11));
        foreach (tv[i]) step(tv[i], i);
        // reset with three live slots: outputs forced low, then readers issue freely
        step(mk(1, 1, 16, 1, 15, 1, 21, 1, 0, 1, IDLE, 11), 100);
        step(mk(1, 1, 16, 1, 15, 1, 21, 1, 0, 0, IDLE, 0), 101);
        step(mk(0, 1, 16, 1, 15, 1, 21, 1, 0, 0, IDLE, 0), 102);
        step(mk(0, 1, 14, 1, 14, 1, 0, 0, 0, 0, IDLE, 0), 103);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain got %0d left want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
